i2c_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `i2c` master between `NUM_REQ` on-chip requesters. It latches a granted requester's transaction (address, data, rw, byte count) and launches it on the master with `m_start`. It tracks the master's `ready` handshake through the transfer and returns the read data and acknowledge status to the owning requester with a one-cycle `done` pulse. It sits between the sensor/config clients and the `i2c` master instance.

---
 rtl/i2c_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter and sequencer sharing one i2c master
// between NUM_REQ requesters. The granted requester's payload is latched,
// launched with m_start, tracked through the master's m_ready handshake, and
// answered with a one-cycle done pulse plus rsp_data/rsp_ack/rsp_err.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN.
//
// Handshake with the master: m_start is held high with stable m_* until the
// master drops m_ready (transfer accepted). The transfer is finished when
// m_ready returns high; only then are the master's result inputs sampled.
// The master's reset is expected to be driven as ~rst_n by the parent.
module i2c_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [7*NUM_REQ-1:0]    req_addr,
    input  logic [16*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [NUM_REQ-1:0]      req_two_bytes,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic [15:0]             rsp_data,
    output logic                    rsp_ack,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    m_start,
    output logic                    m_rw,
    output logic                    m_two_bytes,
    output logic [6:0]              m_addr,
    output logic [15:0]             m_data,
    input  logic                    m_ready,
    input  logic                    m_got_ack,
    input  logic [15:0]             m_read_data,
    output logic [1:0]              dbg_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
`ifdef I2C_ARB_TIMEOUT_EN
        BUSY  = 2'd2,
        DRAIN = 2'd3
`else
        BUSY  = 2'd2
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 m_start_q, m_start_d;
    logic [6:0]           m_addr_q, m_addr_d;
    logic [15:0]          m_data_q, m_data_d;
    logic                 m_rw_q, m_rw_d;
    logic                 m_two_q, m_two_d;
    logic [15:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_ack_q, rsp_ack_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;

    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [6:0]           sel_addr;
    logic [15:0]          sel_data;
    logic                 sel_rw;
    logic                 sel_two;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0]          wd_q, wd_d;
    logic                 wd_expired;
    logic                 do_abort;
    assign wd_expired = (wd_q == (TIMEOUT_CYCLES - 16'd1));
`else
    logic                 unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // (base + off) modulo NUM_REQ, for the rotating scan and pointer advance
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Pick the first requester at or above ptr (with wrap) and mux its payload
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        sel_addr    = '0;
        sel_data    = '0;
        sel_rw      = 1'b0;
        sel_two     = 1'b0;
        // Descending scan so the smallest offset from ptr is written last
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr_q, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(ptr_q, k);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PW'(i)) begin
                pick_onehot[i] = 1'b1;
                sel_addr       = req_addr[7*i +: 7];
                sel_data       = req_data[16*i +: 16];
                sel_rw         = req_rw[i];
                sel_two        = req_two_bytes[i];
            end
        end
    end

    // Next-state and next-output logic; every output is a register
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        done_d     = '0;
        m_start_d  = m_start_q;
        m_addr_d   = m_addr_q;
        m_data_d   = m_data_q;
        m_rw_d     = m_rw_q;
        m_two_d    = m_two_q;
        rsp_data_d = rsp_data_q;
        rsp_ack_d  = rsp_ack_q;
        rsp_err_d  = rsp_err_q;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d       = wd_q;
        do_abort   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m_ready && pick_found) begin
                    owner_d   = pick_idx;
                    grant_d   = pick_onehot;
                    m_start_d = 1'b1;
                    m_addr_d  = sel_addr;
                    m_data_d  = sel_data;
                    m_rw_d    = sel_rw;
                    m_two_d   = sel_two;
                    state_d   = ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
                    wd_d      = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                if (!m_ready) begin
                    m_start_d = 1'b0;
                    state_d   = BUSY;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    do_abort = 1'b1;
                end
`endif
            end
            BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
`endif
                if (m_ready) begin
                    rsp_data_d = m_rw_q ? m_read_data : 16'd0;
                    rsp_ack_d  = m_got_ack;
                    rsp_err_d  = 1'b0;
                    done_d     = grant_q;
                    grant_d    = '0;
                    ptr_d      = wrap_add(owner_q, 1);
                    state_d    = IDLE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    do_abort = 1'b1;
                end
`endif
            end
`ifdef I2C_ARB_TIMEOUT_EN
            DRAIN: begin
                // Master is still mid-transfer; wait for it before arbitrating
                if (m_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef I2C_ARB_TIMEOUT_EN
        if (do_abort) begin
            done_d     = grant_q;
            rsp_err_d  = 1'b1;
            rsp_ack_d  = 1'b0;
            rsp_data_d = 16'd0;
            grant_d    = '0;
            m_start_d  = 1'b0;
            ptr_d      = wrap_add(owner_q, 1);
            state_d    = DRAIN;
        end
`endif
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            m_start_q  <= 1'b0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            m_rw_q     <= 1'b0;
            m_two_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_ack_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            m_start_q  <= m_start_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
            m_rw_q     <= m_rw_d;
            m_two_q    <= m_two_d;
            rsp_data_q <= rsp_data_d;
            rsp_ack_q  <= rsp_ack_d;
            rsp_err_q  <= rsp_err_d;
            busy_q     <= busy_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign m_start     = m_start_q;
    assign m_addr      = m_addr_q;
    assign m_data      = m_data_q;
    assign m_rw        = m_rw_q;
    assign m_two_bytes = m_two_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_ack     = rsp_ack_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: bench for i2c_arbiter with a behavioural i2c master/slave
// model, a transaction-level reference of the arbitration rules, directed
// vectors, and (with I2C_ARB_TIMEOUT_EN) a watchdog sequence.
`timescale 1ns/1ps
module tb_i2c_arbiter;

    localparam int N = 4;

    typedef struct packed {
        int          idx;
        logic [6:0]  addr;
        logic [15:0] data;
        logic        rw;
        logic        two;
        logic [N-1:0] exp_grant;
        logic [15:0] exp_rsp;
        logic        exp_ack;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [7*N-1:0]  req_addr = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]    req_rw = '0;
    logic [N-1:0]    req_two_bytes = '0;
    logic [N-1:0]    grant, done;
    logic [15:0]     rsp_data;
    logic            rsp_ack, rsp_err, busy;
    logic            m_start, m_rw, m_two_bytes;
    logic [6:0]      m_addr;
    logic [15:0]     m_data;
    logic            m_ready = 1'b0;
    logic            m_got_ack = 1'b0;
    logic [15:0]     m_read_data = '0;
    logic [1:0]      dbg_state;

    i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16'd64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_rw(req_rw), .req_two_bytes(req_two_bytes),
        .grant(grant), .done(done),
        .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_err(rsp_err),
        .busy(busy),
        .m_start(m_start), .m_rw(m_rw), .m_two_bytes(m_two_bytes),
        .m_addr(m_addr), .m_data(m_data),
        .m_ready(m_ready), .m_got_ack(m_got_ack), .m_read_data(m_read_data),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave behaviour ----------------
    function automatic logic slave_ack(input logic [6:0] a);
        return a != 7'h7F;
    endfunction

    function automatic logic [15:0] slave_word(input logic [6:0] a, input logic two);
        logic [15:0] w;
        if (a == 7'h7F)      w = 16'h0000;
        else if (a == 7'h1D) w = 16'hBEEF;
        else                 w = {a, ~a, 2'b01};
        return two ? w : {8'h00, w[7:0]};
    endfunction

    // ---------------- master model (drives on negedge) ----------------
    logic       hold_low = 1'b0;
    logic       mst_busy = 1'b0;
    logic       mst_init = 1'b1;
    int         mst_cnt  = 0;
    logic [6:0] mst_addr = '0;
    logic       mst_rw   = 1'b0;
    logic       mst_two  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mst_busy = 1'b0;
            mst_init = 1'b1;
            m_ready  = 1'b0;
        end else if (mst_init) begin
            mst_init = 1'b0;
            m_ready  = 1'b0;
        end else begin
            if (!mst_busy) begin
                if (m_start) begin
                    mst_busy = 1'b1;
                    mst_cnt  = $urandom_range(0, 5);
                    mst_addr = m_addr;
                    mst_rw   = m_rw;
                    mst_two  = m_two_bytes;
                end
            end else if (mst_cnt == 0) begin
                mst_busy    = 1'b0;
                m_got_ack   = slave_ack(mst_addr);
                m_read_data = mst_rw ? slave_word(mst_addr, mst_two) : 16'($urandom);
            end else begin
                mst_cnt = mst_cnt - 1;
            end
            m_ready = !mst_busy && !hold_low;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic         chk_en = 1'b1;
    int           ref_ptr = 0;
    int           ref_owner = 0;
    logic         ref_open = 1'b0;
    logic         ref_issue = 1'b0;
    logic         chk_payload = 1'b0;
    logic [6:0]   ref_addr = '0;
    logic [15:0]  ref_data = '0;
    logic         ref_rw = 1'b0;
    logic         ref_two = 1'b0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_done = '0;
    logic [15:0]  exp_q[$];
    logic [15:0]  e_rsp_data = '0;
    logic         e_ack = 1'b0;

    // first set request scanning upward from p, wrapping
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            ref_ptr = 0; ref_open = 1'b0; ref_issue = 1'b0;
            e_grant = '0; e_done = '0; e_rsp_data = '0; e_ack = 1'b0;
            exp_q.delete();
        end else if (chk_en) begin
            e_done = '0;
            chk_payload = 1'b0;
            if (!ref_open) begin
                if (m_ready && req != '0) begin
                    ref_owner = rr_pick(req, ref_ptr);
                    ref_open  = 1'b1;
                    ref_issue = 1'b1;
                    ref_addr  = req_addr[7*ref_owner +: 7];
                    ref_data  = req_data[16*ref_owner +: 16];
                    ref_rw    = req_rw[ref_owner];
                    ref_two   = req_two_bytes[ref_owner];
                    exp_q.push_back(ref_rw ? slave_word(ref_addr, ref_two) : 16'h0000);
                    chk_payload = 1'b1;
                end
            end else if (ref_issue) begin
                if (!m_ready) ref_issue = 1'b0;
            end else if (m_ready) begin
                e_done     = N'(1) << ref_owner;
                e_rsp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
                e_ack      = slave_ack(ref_addr);
                ref_open   = 1'b0;
                ref_ptr    = (ref_owner + 1) % N;
            end
            e_grant = ref_open ? (N'(1) << ref_owner) : '0;
            #1;
            check("sb_grant", grant, e_grant);
            check("sb_done", done, e_done);
            check("sb_m_start", m_start, ref_open && ref_issue);
            check("sb_busy", busy, ref_open);
            check("sb_rsp_data", rsp_data, e_rsp_data);
            check("sb_rsp_ack", rsp_ack, e_ack);
            check("sb_rsp_err", rsp_err, 1'b0);
            if (chk_payload) begin
                check("sb_m_addr", m_addr, ref_addr);
                check("sb_m_data", m_data, ref_data);
                check("sb_m_rw", m_rw, ref_rw);
                check("sb_m_two", m_two_bytes, ref_two);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int t;
        @(negedge clk);
        req_addr[7*v.idx +: 7]   = v.addr;
        req_data[16*v.idx +: 16] = v.data;
        req_rw[v.idx]            = v.rw;
        req_two_bytes[v.idx]     = v.two;
        req = '0;
        req[v.idx] = 1'b1;
        t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (grant == '0 && t < 40);
        check({tag, "_grant"}, grant, v.exp_grant);
        req = '0;
        t = 0;
        while (done == '0 && t < 60) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_done"}, done, v.exp_grant);
        check({tag, "_rsp_data"}, rsp_data, v.exp_rsp);
        check({tag, "_rsp_ack"}, rsp_ack, v.exp_ack);
        check({tag, "_rsp_err"}, rsp_err, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || done != '0) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    vec_t         vecs[6];
    logic [N-1:0] rr_exp[5];
    logic [N-1:0] order[$];

    initial begin
        int t;
        int cnt;
        logic [N-1:0] prev;

        vecs[0] = '{idx: 1, addr: 7'h48, data: 16'h00A5, rw: 1'b0, two: 1'b0, exp_grant: 4'b0010, exp_rsp: 16'h0000, exp_ack: 1'b1};
        vecs[1] = '{idx: 0, addr: 7'h1D, data: 16'h1111, rw: 1'b1, two: 1'b1, exp_grant: 4'b0001, exp_rsp: 16'hBEEF, exp_ack: 1'b1};
        vecs[2] = '{idx: 2, addr: 7'h7F, data: 16'h1234, rw: 1'b0, two: 1'b1, exp_grant: 4'b0100, exp_rsp: 16'h0000, exp_ack: 1'b0};
        vecs[3] = '{idx: 3, addr: 7'h7F, data: 16'h5555, rw: 1'b1, two: 1'b1, exp_grant: 4'b1000, exp_rsp: 16'h0000, exp_ack: 1'b0};
        vecs[4] = '{idx: 3, addr: 7'h1D, data: 16'h0000, rw: 1'b1, two: 1'b0, exp_grant: 4'b1000, exp_rsp: 16'h00EF, exp_ack: 1'b1};
        vecs[5] = '{idx: 2, addr: 7'h50, data: 16'hCAFE, rw: 1'b1, two: 1'b1, exp_grant: 4'b0100, exp_rsp: 16'hA0BD, exp_ack: 1'b1};
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        // reset values while rst_n is low
        #12;
        check("rst_grant", grant, '0);
        check("rst_done", done, '0);
        check("rst_m_start", m_start, 1'b0);
        check("rst_m_addr", m_addr, 7'h00);
        check("rst_m_data", m_data, 16'h0000);
        check("rst_m_rw_two", {m_rw, m_two_bytes}, 2'b00);
        check("rst_rsp", {rsp_data, rsp_ack, rsp_err}, 18'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // directed vectors
        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // round-robin with all requests held from reset
        for (int i = 0; i < N; i++) begin
            req_addr[7*i +: 7]   = 7'h10 + 7'(i);
            req_data[16*i +: 16] = 16'(i);
        end
        req_rw = '0;
        req_two_bytes = '0;
        @(negedge clk);
        rst_n = 1'b0;
        req = '1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        prev = '0;
        t = 0;
        while (order.size() < 5 && t < 300) begin
            @(posedge clk); #1; t++;
            if (grant != '0 && prev == '0) order.push_back(grant);
            prev = grant;
        end
        check("rr_count", order.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_grant%0d", i), (i < order.size()) ? order[i] : '0, rr_exp[i]);
        req = '0;
        wait_idle();

        // reset in the middle of a transfer
        @(negedge clk);
        req_addr[7 +: 7] = 7'h48;
        req_data[16 +: 16] = 16'h00A5;
        req_rw[1] = 1'b0;
        req = 4'b0010;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (grant == '0 && t < 40);
        req = '0;
        t = 0;
        while (m_start && t < 40) begin @(posedge clk); #1; t++; end
        check("mid_in_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_grant", grant, '0);
        check("mid_m_start", m_start, 1'b0);
        check("mid_m_payload", {m_addr, m_data, m_rw, m_two_bytes}, '0);
        check("mid_rsp", {rsp_data, rsp_ack, rsp_err, done}, '0);
        check("mid_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin @(posedge clk); #1; if (done != '0) cnt++; end
        check("mid_no_done", cnt, 0);
        run_txn(vecs[0], "post_rst");

        // randomized traffic against the reference model
        repeat (800) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                req_addr[7*i +: 7]   = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom);
                req_data[16*i +: 16] = 16'($urandom);
                req_rw[i]            = 1'($urandom);
                req_two_bytes[i]     = 1'($urandom);
            end
        end
        @(negedge clk);
        req = '0;
        wait_idle();

`ifdef I2C_ARB_TIMEOUT_EN
        // watchdog abort with the master stuck
        chk_en = 1'b0;
        do_reset();
        @(negedge clk);
        req_addr[0 +: 7] = 7'h48;
        req_rw[0] = 1'b0;
        req = 4'b0001;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (grant == '0 && t < 40);
        check("to_grant", grant, 4'b0001);
        hold_low = 1'b1;
        t = 0;
        while (done == '0 && t < 200) begin @(posedge clk); #1; t++; end
        check("to_latency", t, 64);
        check("to_done", done, 4'b0001);
        check("to_rsp", {rsp_data, rsp_ack, rsp_err}, 18'h1);
        check("to_grant_clr", {grant, m_start}, '0);
        cnt = 0;
        repeat (20) begin @(posedge clk); #1; if (grant != '0) cnt++; end
        check("to_no_grant", cnt, 0);
        check("to_busy_drain", busy, 1'b1);
        hold_low = 1'b0;
        t = 0;
        while (grant == '0 && t < 20) begin @(posedge clk); #1; t++; end
        check("to_regrant", grant, 4'b0001);
        req = '0;
        t = 0;
        while (done == '0 && t < 60) begin @(posedge clk); #1; t++; end
        check("to_done2", done, 4'b0001);
        check("to_err2", rsp_err, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
